// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris core: default playfield geometry,
// gravity period and the game state enumeration.
package tetris_pkg;

  localparam int unsigned COLS_DEF = 10;
  localparam int unsigned ROWS_DEF = 16;
  localparam int unsigned DROP_DEF = 8;

  typedef enum logic [2:0] {
    ST_I,
    ST_GEN,
    ST_FALL,
    ST_LOCK,
    ST_CLR,
    ST_OVER
  } state_t;

endpackage

// File: rtl/tetris_row_clear.sv
// Combinational full-row handling for the tetris board.
//   board      : current board, bit row*COLS+col, row 0 at top
//   any_full   : at least one row of board is completely filled
//   board_out  : board with the lowest full row removed (rows above shift
//                down one, row 0 becomes empty); equals board if none full
//   full_after : board_out still contains a full row
module tetris_row_clear
  import tetris_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic [COLS*ROWS-1:0] board,
  output logic                 any_full,
  output logic                 full_after,
  output logic [COLS*ROWS-1:0] board_out
);

  always_comb begin
    int unsigned sel;
    any_full = 1'b0;
    sel      = 0;
    // Scanning top to bottom, the last hit is the lowest full row.
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (&board[r*COLS +: COLS]) begin
        any_full = 1'b1;
        sel      = r;
      end
    end

    board_out = board;
    if (any_full) begin
      for (int unsigned r = 1; r < ROWS; r++) begin
        if (r <= sel) board_out[r*COLS +: COLS] = board[(r-1)*COLS +: COLS];
      end
      board_out[0 +: COLS] = '0;
    end

    full_after = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (&board_out[r*COLS +: COLS]) full_after = 1'b1;
    end
  end

endmodule

// File: rtl/tetris_core.sv
// Minimal tetris engine with a 2x2 piece.
//   Clk, Reset            : clock (rising edge), async active-high reset
//   Start, Ack            : begin game from idle, acknowledge game over
//   Left, Right, Down     : level controls, only honoured while falling
//   q_I .. q_Over         : one-hot state flags
//   blocks                : board plus falling piece, bit row*COLS+col
//   score                 : rows cleared this game (saturating)
module tetris_core
  import tetris_pkg::*;
#(
  parameter int unsigned COLS        = COLS_DEF,
  parameter int unsigned ROWS        = ROWS_DEF,
  parameter int unsigned DROP_PERIOD = DROP_DEF,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic                 Left,
  input  logic                 Right,
  input  logic                 Down,
  output logic                 q_I,
  output logic                 q_Gen,
  output logic                 q_Fall,
  output logic                 q_Lock,
  output logic                 q_Clr,
  output logic                 q_Over,
  output logic [COLS*ROWS-1:0] blocks,
  output logic [SCORE_W-1:0]   score
);

  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned PW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned DW = $clog2(DROP_PERIOD + 1);

  localparam logic [CW-1:0] SPAWN_C = CW'(COLS / 2 - 1);
  localparam logic [CW-1:0] MAX_C   = CW'(COLS - 2);
  localparam logic [PW-1:0] MAX_R   = PW'(ROWS - 2);
  localparam logic [DW-1:0] LAST_D  = DW'(DROP_PERIOD - 1);

  // Cells covered by a 2x2 piece anchored at (r, c).
  function automatic logic [N-1:0] piece_mask(input int unsigned r, input int unsigned c);
    int unsigned base;
    base = r * COLS + c;
    return (N'(3) << base) | (N'(3) << (base + COLS));
  endfunction

  function automatic logic fits(input logic [N-1:0] b, input int unsigned r,
                                input int unsigned c);
    return (piece_mask(r, c) & b) == '0;
  endfunction

  state_t          state, nxt;
  logic [N-1:0]    board, board_shift;
  logic            any_full, full_after;
  logic [PW-1:0]   prow;
  logic [CW-1:0]   pcol, pcol_h;
  logic [DW-1:0]   dcnt;
  logic            grav, can_fall, spawn_ok;

  tetris_row_clear #(.COLS(COLS), .ROWS(ROWS)) u_row_clear (
    .board      (board),
    .any_full   (any_full),
    .full_after (full_after),
    .board_out  (board_shift)
  );

  // Horizontal move first, then gravity tested against the moved column.
  always_comb begin
    pcol_h = pcol;
    if (Left && !Right && pcol != '0 && fits(board, 32'(prow), 32'(pcol) - 1))
      pcol_h = pcol - 1'b1;
    else if (Right && !Left && pcol < MAX_C && fits(board, 32'(prow), 32'(pcol) + 1))
      pcol_h = pcol + 1'b1;
    grav     = (dcnt == LAST_D) || Down;
    can_fall = (prow != MAX_R) && fits(board, 32'(prow) + 1, 32'(pcol_h));
    spawn_ok = fits(board, 0, 32'(SPAWN_C));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_I;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_I:    if (Start) nxt = ST_GEN;
      ST_GEN:  nxt = spawn_ok ? ST_FALL : ST_OVER;
      ST_FALL: if (grav && !can_fall) nxt = ST_LOCK;
      ST_LOCK: nxt = ST_CLR;
      // Leave only once the row being removed now is the last full one.
      ST_CLR:  nxt = (any_full && full_after) ? ST_CLR : ST_GEN;
      ST_OVER: if (Ack) nxt = ST_I;
      default: nxt = ST_I;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      board <= '0;
      score <= '0;
      prow  <= '0;
      pcol  <= SPAWN_C;
      dcnt  <= '0;
    end else begin
      unique case (state)
        ST_I: if (Start) begin
          board <= '0;
          score <= '0;
        end
        ST_GEN: begin
          prow <= '0;
          pcol <= SPAWN_C;
          dcnt <= '0;
        end
        ST_FALL: begin
          pcol <= pcol_h;
          if (grav) begin
            dcnt <= '0;
            if (can_fall) prow <= prow + 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_LOCK: board <= board | piece_mask(32'(prow), 32'(pcol));
        ST_CLR: if (any_full) begin
          board <= board_shift;
          if (score != '1) score <= score + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blocks = board;
    if (state == ST_GEN || state == ST_FALL)
      blocks = board | piece_mask(32'(prow), 32'(pcol));
  end

  assign q_I    = (state == ST_I);
  assign q_Gen  = (state == ST_GEN);
  assign q_Fall = (state == ST_FALL);
  assign q_Lock = (state == ST_LOCK);
  assign q_Clr  = (state == ST_CLR);
  assign q_Over = (state == ST_OVER);

endmodule

// File: tb/tb_tetris_core.sv
module tb_tetris_core;

  localparam int C  = 10;
  localparam int R  = 16;
  localparam int DP = 4;
  localparam int SW = 16;

  localparam int M_I = 0, M_GEN = 1, M_FALL = 2, M_LOCK = 3, M_CLR = 4, M_OVER = 5;

  logic Clk_tb = 1'b0;
  logic Reset = 1'b0, Start = 1'b0, Ack = 1'b0, Left = 1'b0, Right = 1'b0, Down = 1'b0;
  logic q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over;
  logic [C*R-1:0] blocks;
  logic [SW-1:0]  score;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: board as rows of cells, piece anchor, drop counter.
  int m_st, mr, mc, md, ms;
  logic [C-1:0] mb [R];

  always #5 Clk_tb = ~Clk_tb;

  tetris_core #(.COLS(C), .ROWS(R), .DROP_PERIOD(DP), .SCORE_W(SW)) dut (
    .Clk(Clk_tb), .Reset(Reset), .Start(Start), .Ack(Ack),
    .Left(Left), .Right(Right), .Down(Down),
    .q_I(q_I), .q_Gen(q_Gen), .q_Fall(q_Fall), .q_Lock(q_Lock),
    .q_Clr(q_Clr), .q_Over(q_Over), .blocks(blocks), .score(score)
  );

  function automatic bit m_fits(int r, int c);
    if (r < 0 || r > R - 2 || c < 0 || c > C - 2) return 1'b0;
    return !(mb[r][c] || mb[r][c+1] || mb[r+1][c] || mb[r+1][c+1]);
  endfunction

  function automatic logic [C*R-1:0] m_blocks();
    logic [C*R-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        v[r*C+c] = mb[r][c];
    if (m_st == M_GEN || m_st == M_FALL) begin
      v[mr*C+mc] = 1'b1;     v[mr*C+mc+1] = 1'b1;
      v[(mr+1)*C+mc] = 1'b1; v[(mr+1)*C+mc+1] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [5:0] m_flags();
    logic [5:0] one;
    one = 6'b100000;
    return one >> m_st;
  endfunction

  task automatic model_reset();
    m_st = M_I; mr = 0; mc = C/2 - 1; md = 0; ms = 0;
    for (int r = 0; r < R; r++) mb[r] = '0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit l, input bit r, input bit d);
    int dx, nfull, low;
    case (m_st)
      M_I: if (s) begin
        for (int k = 0; k < R; k++) mb[k] = '0;
        ms = 0;
        m_st = M_GEN;
      end
      M_GEN: begin
        mr = 0; mc = C/2 - 1; md = 0;
        m_st = m_fits(0, mc) ? M_FALL : M_OVER;
      end
      M_FALL: begin
        dx = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        if (dx != 0 && m_fits(mr, mc + dx)) mc = mc + dx;
        if (md == DP - 1 || d) begin
          md = 0;
          if (m_fits(mr + 1, mc)) mr++;
          else m_st = M_LOCK;
        end else begin
          md++;
        end
      end
      M_LOCK: begin
        mb[mr][mc] = 1'b1;   mb[mr][mc+1] = 1'b1;
        mb[mr+1][mc] = 1'b1; mb[mr+1][mc+1] = 1'b1;
        m_st = M_CLR;
      end
      M_CLR: begin
        nfull = 0; low = -1;
        for (int k = 0; k < R; k++)
          if (mb[k] == '1) begin nfull++; low = k; end
        if (nfull > 0) begin
          for (int k = low; k > 0; k--) mb[k] = mb[k-1];
          mb[0] = '0;
          if (ms < (1 << SW) - 1) ms++;
        end
        m_st = (nfull > 1) ? M_CLR : M_GEN;
      end
      M_OVER: if (a) m_st = M_I;
      default: m_st = M_I;
    endcase
  endtask

  // Drive inputs, take one clock edge in DUT and model, settle 1 time unit.
  task automatic tick(input bit s, input bit a, input bit l, input bit r, input bit d);
    Start = s; Ack = a; Left = l; Right = r; Down = d;
    @(posedge Clk_tb);
    model_step(s, a, l, r, d);
    #1;
  endtask

  task automatic new_game();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
    tick(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1;
    repeat (2) @(posedge Clk_tb);
    #1;
    n_cmp++;
    if ({q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_flags got %b want 100000", {q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over});
    end
    n_cmp++;
    if (blocks !== '0) begin n_bad++; $display("FAIL reset_blocks got %h want 0", blocks); end
    n_cmp++;
    if (score !== '0) begin n_bad++; $display("FAIL reset_score got %0d want 0", score); end
    Reset = 1'b0; Start = 1'b0;
    model_reset();
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (q_I !== 1'b1) begin n_bad++; $display("FAIL reset_hold got q_I=%b want 1", q_I); end
  endtask

  task automatic test_plain_drop();
    logic [C*R-1:0] exp;
    int cnt;
    new_game();
    n_cmp++;
    if (q_Gen !== 1'b1) begin n_bad++; $display("FAIL plain_gen got q_Gen=%b want 1", q_Gen); end
    tick(0, 0, 0, 0, 0);
    cnt = 0;
    while (q_Fall === 1'b1 && cnt < 200) begin tick(0, 0, 0, 0, 0); cnt++; end
    n_cmp++;
    if (cnt != 60 || q_Lock !== 1'b1) begin
      n_bad++; $display("FAIL plain_fall_len got %0d cycles q_Lock=%b want 60 cycles q_Lock=1", cnt, q_Lock);
    end
    tick(0, 0, 0, 0, 0);
    exp = '0;
    exp[144] = 1'b1; exp[145] = 1'b1; exp[154] = 1'b1; exp[155] = 1'b1;
    n_cmp++;
    if (blocks !== exp) begin n_bad++; $display("FAIL plain_blocks got %h want %h", blocks, exp); end
    n_cmp++;
    if (score !== '0) begin n_bad++; $display("FAIL plain_score got %0d want 0", score); end
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (q_Gen !== 1'b1) begin n_bad++; $display("FAIL plain_regen got q_Gen=%b want 1", q_Gen); end
  endtask

  task automatic test_steer();
    logic [C*R-1:0] exp;
    new_game();
    tick(0, 0, 0, 0, 0);
    repeat (10) tick(0, 0, 0, 1, 0);
    // Gravity at Fall cycles 4 and 8: anchor row 2, column clamped at 8.
    exp = '0;
    exp[28] = 1'b1; exp[29] = 1'b1; exp[38] = 1'b1; exp[39] = 1'b1;
    n_cmp++;
    if (blocks !== exp) begin n_bad++; $display("FAIL steer_right got %h want %h", blocks, exp); end
    new_game();
    tick(0, 0, 0, 0, 0);
    repeat (6) tick(0, 0, 1, 1, 0);
    exp = '0;
    exp[14] = 1'b1; exp[15] = 1'b1; exp[24] = 1'b1; exp[25] = 1'b1;
    n_cmp++;
    if (blocks !== exp) begin n_bad++; $display("FAIL steer_both got %h want %h", blocks, exp); end
  endtask

  // From Gen: steer to column t while forcing gravity, lock, run Clr to Gen.
  task automatic drop_piece(input int t, output int nclr);
    int guard;
    tick(0, 0, 0, 0, 0);
    for (int k = 0; k < ((t < 4) ? 4 - t : t - 4); k++) tick(0, 0, t < 4, t > 4, 1);
    guard = 0;
    while (m_st == M_FALL && guard < 40) begin tick(0, 0, 0, 0, 1); guard++; end
    if (m_st == M_LOCK) tick(0, 0, 0, 0, 0);
    nclr = 0;
    while (m_st == M_CLR && nclr < 20) begin tick(0, 0, 0, 0, 0); nclr++; end
    n_cmp++;
    if ({q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over} !== m_flags() || blocks !== m_blocks()) begin
      n_bad++;
      $display("FAIL drop_piece col %0d got flags %b blocks %h want flags %b blocks %h",
               t, {q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over}, blocks, m_flags(), m_blocks());
    end
  endtask

  task automatic test_clear();
    logic [C*R-1:0] exp;
    int nclr;
    new_game();
    for (int i = 0; i < 5; i++) drop_piece(2 * i, nclr);
    n_cmp++;
    if (nclr != 2) begin n_bad++; $display("FAIL clear_cycles got %0d want 2", nclr); end
    n_cmp++;
    if (score !== 16'd2) begin n_bad++; $display("FAIL clear_score got %0d want 2", score); end
    // Board is empty; Gen overlays the piece at the last anchor (14,8).
    exp = '0;
    exp[148] = 1'b1; exp[149] = 1'b1; exp[158] = 1'b1; exp[159] = 1'b1;
    n_cmp++;
    if (q_Gen !== 1'b1 || blocks !== exp) begin
      n_bad++; $display("FAIL clear_board got q_Gen=%b blocks %h want q_Gen=1 blocks %h", q_Gen, blocks, exp);
    end
  endtask

  task automatic test_async_reset();
    tick(0, 0, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over} !== 6'b100000) begin
      n_bad++; $display("FAIL async_flags got %b want 100000", {q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over});
    end
    n_cmp++;
    if (blocks !== '0 || score !== '0) begin
      n_bad++; $display("FAIL async_clear got blocks %h score %0d want 0 and 0", blocks, score);
    end
    #1;
    Reset = 1'b0;
    model_reset();
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (q_I !== 1'b1) begin n_bad++; $display("FAIL async_idle got q_I=%b want 1", q_I); end
  endtask

  task automatic test_over();
    int nclr;
    new_game();
    for (int i = 0; i < 8; i++) drop_piece(4, nclr);
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (q_Over !== 1'b1) begin n_bad++; $display("FAIL over_enter got q_Over=%b want 1", q_Over); end
    tick(1, 0, 0, 0, 0);
    n_cmp++;
    if (q_Over !== 1'b1 || blocks !== m_blocks()) begin
      n_bad++; $display("FAIL over_start_ignored got q_Over=%b blocks %h want 1 blocks %h", q_Over, blocks, m_blocks());
    end
    tick(0, 1, 0, 0, 0);
    n_cmp++;
    if (q_I !== 1'b1) begin n_bad++; $display("FAIL over_ack got q_I=%b want 1", q_I); end
  endtask

  task automatic test_down();
    int cnt;
    new_game();
    tick(0, 0, 0, 0, 1);
    cnt = 0;
    while (q_Fall === 1'b1 && cnt < 100) begin tick(0, 0, 0, 0, 1); cnt++; end
    n_cmp++;
    if (cnt != 15 || q_Lock !== 1'b1) begin
      n_bad++; $display("FAIL down_fall_len got %0d cycles q_Lock=%b want 15 cycles q_Lock=1", cnt, q_Lock);
    end
  endtask

  task automatic test_random();
    bit s, a, l, r, d;
    new_game();
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 4) == 0);
      tick(s, a, l, r, d);
      n_cmp++;
      if ({q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over} !== m_flags()) begin
        n_bad++; $display("FAIL rand_flags cyc %0d got %b want %b", i, {q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over}, m_flags());
      end
      n_cmp++;
      if (blocks !== m_blocks()) begin
        n_bad++; $display("FAIL rand_blocks cyc %0d got %h want %h", i, blocks, m_blocks());
      end
      n_cmp++;
      if (score !== SW'(ms)) begin
        n_bad++; $display("FAIL rand_score cyc %0d got %0d want %0d", i, score, ms);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_plain_drop();
    test_steer();
    test_clear();
    test_async_reset();
    test_over();
    test_down();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tetris_core.md
TETRIS_CORE -- requirements
Module: tetris_core

Interface
REQ-001 SHALL have parameter COLS, default 10, playfield width in cells (>=4).
REQ-002 SHALL have parameter ROWS, default 16, playfield height in cells (>=4).
REQ-003 SHALL have parameter DROP_PERIOD, default 8, Fall cycles per gravity step (>=1).
REQ-004 SHALL have parameter SCORE_W, default 16, score counter width.
REQ-005 SHALL have ports, in this order:
- Clk  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin game from idle.
- Ack  in  1  acknowledge game over.
- Left  in  1  level; move piece one column left per Fall cycle.
- Right  in  1  level; move piece one column right per Fall cycle.
- Down  in  1  level; force a gravity step this cycle.
- q_I, q_Gen, q_Fall, q_Lock, q_Clr, q_Over  out  1 each  one-hot state flags.
- blocks  out  COLS*ROWS  board plus falling piece; bit row*COLS+col, row 0 at top.
- score  out  SCORE_W  rows cleared this game.

Function
REQ-006 SHALL use a 2x2 piece with top-left anchor (prow, pcol).
REQ-007 SHALL, in state I, go to Gen on Start, clearing the board and score on that edge; otherwise it SHALL hold.
REQ-008 SHALL, in state Gen (one cycle), set prow=0, pcol=COLS/2-1 and reset the drop counter; it SHALL go to Over if any of the four cells is occupied, else to Fall.
REQ-009 SHALL, in state Fall with Left=1 and Right=0, decrement pcol only if pcol>0 and both target cells are free; the mirror rule SHALL apply to Right with pcol<COLS-2.
REQ-010 SHALL apply no horizontal move when Left and Right are both asserted.
REQ-011 SHALL, in Fall, increment the drop counter each cycle; a gravity step SHALL occur when the counter equals DROP_PERIOD-1 or Down=1, and the counter SHALL then clear.
REQ-012 SHALL evaluate the gravity step against the post-horizontal position in the same cycle: if prow==ROWS-2 or a cell below is occupied, go to Lock; else prow+1.
REQ-013 SHALL, in Lock (one cycle), OR the four piece cells into the board and go to Clr.
REQ-014 SHALL, in Clr, remove the lowest full row per cycle: rows above it shift down one, row 0 is zeroed, and score increments (saturating at all-ones). It SHALL stay in Clr while any full row exists, else go to Gen.
REQ-015 SHALL, in Over, freeze the board and score, go to I on Ack, and ignore Start.
REQ-016 SHALL drive blocks as board OR piece cells in Gen/Fall, and board only in all other states.
REQ-017 SHALL ignore Left/Right/Down outside Fall.

Reset
REQ-018 SHALL, on Reset=1, immediately and asynchronously set state I (q_I=1, other flags 0), board 0, blocks 0, score 0, prow 0, pcol COLS/2-1 and drop counter 0, regardless of the current state.
REQ-019 SHALL hold these values while Reset stays high, and SHALL leave I only on a Start sampled after Reset deasserts.

Structure
REQ-020 SHALL place the state enumeration and the default values of COLS, ROWS and DROP_PERIOD in shared package tetris_pkg.
REQ-021 SHALL implement full-row detection, lowest-full-row select and the shift-down in sub-module tetris_row_clear, parametrised by COLS and ROWS.
REQ-022 SHALL contain no other sub-modules, and all storage SHALL live in tetris_core.

Verification (COLS=10, ROWS=16, DROP_PERIOD=4)
REQ-023 SHALL cover: Start, no moves -> Gen 1 cycle, Fall 60 cycles, Lock; blocks bits 144,145,154,155 set; score 0.
REQ-024 SHALL cover: Right held 10 Fall cycles -> pcol saturates at 8; Left+Right held together -> pcol stays 4.
REQ-025 SHALL cover: five pieces steered to pcol 0,2,4,6,8 -> two Clr cycles, score=2, blocks=0, then Gen.
REQ-026 SHALL cover: eight unsteered pieces stack column 4-5 -> the ninth Gen gives q_Over=1; Ack -> q_I=1 next cycle; Start ignored while in Over.
REQ-027 SHALL cover: Reset pulsed mid-Fall, off-edge -> q_I=1, blocks=0 and score=0 before the next Clk edge.
REQ-028 SHALL cover: Down held from Gen -> a gravity step every Fall cycle; Lock after 15 Fall cycles.
